// File: rtl/lvds_pkg.sv
// lvds_pkg: constants, serializer state type and frame helpers shared by frame_tx and frame_tx_ser.
package lvds_pkg;

  localparam int         FRAME_NIBBLES   = 16;
  localparam int         STOP_BITS       = 3;
  localparam int         SAMPLES_PER_BIT = 4;
  localparam logic [7:0] IDLE_WORD       = 8'hFF;
  localparam int         FRAME_CYCLES    = 34;

  localparam int DATA_BITS  = FRAME_NIBBLES * 4;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_DATA,
    SER_GAP
  } ser_state_t;

  // Line order: bit 0 is the start bit, then D[63] down to D[0], then the stop bits.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
    logic [FRAME_BITS-1:0] s;
    s    = '1;
    s[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      s[1+i] = d[DATA_BITS-1-i];
    end
    return s;
  endfunction

  // Two line bits per clock, each repeated SAMPLES_PER_BIT times; the earlier bit lands in the MSBs.
  function automatic logic [7:0] expand_pair(input logic b_first, input logic b_second);
    return {{SAMPLES_PER_BIT{b_first}}, {SAMPLES_PER_BIT{b_second}}};
  endfunction

endpackage

// File: rtl/frame_tx_ser.sv
// frame_tx_ser: frame serializer FSM, shift register and sample expansion.
// Optional build macro: FRAME_TX_SKEW_EN (adds static ph input, delays samples by 0..3).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SER_IDLE | o idle (8'hFF); a valid shadow frame is loaded at once
//   SER_DATA | frame word on o; cnt counts down 33..0 to the last word
//   SER_GAP  | idle words after the frame; cnt counts down GAP-1..0
module frame_tx_ser
  import lvds_pkg::*;
#(
  parameter int GAP = 4
) (
  input  logic                 c,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] load_d,
  input  logic                 load_v,
  output logic                 take,
  output logic [7:0]           o,
  output logic                 busy
`ifdef FRAME_TX_SKEW_EN
  ,
  input  logic [1:0]           ph
`endif
);

  ser_state_t            state, state_nx;
  logic [5:0]            cnt, cnt_nx;
  logic [FRAME_BITS-1:0] shreg, shreg_nx, frame_s;
  logic [7:0]            word_nx, o_nx;

  assign frame_s = build_frame(load_d);
  assign busy    = (state != SER_IDLE);

  // Next state, next raw word and shift-register update; a load overrides everything.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    word_nx  = IDLE_WORD;
    take     = 1'b0;
    case (state)
      SER_IDLE: take = load_v;
      SER_DATA: begin
        if (cnt == 6'd0) begin
          state_nx = SER_GAP;
          cnt_nx   = 6'(GAP - 1);
        end else begin
          cnt_nx   = cnt - 6'd1;
          word_nx  = expand_pair(shreg[0], shreg[1]);
          shreg_nx = shreg >> 2;
        end
      end
      SER_GAP: begin
        if (cnt == 6'd0) begin
          take = load_v;
          if (!load_v) state_nx = SER_IDLE;
        end else begin
          cnt_nx = cnt - 6'd1;
        end
      end
      default: state_nx = SER_IDLE;
    endcase
    if (take) begin
      state_nx = SER_DATA;
      cnt_nx   = 6'(FRAME_CYCLES - 1);
      word_nx  = expand_pair(frame_s[0], frame_s[1]);
      shreg_nx = frame_s >> 2;
    end
  end

`ifdef FRAME_TX_SKEW_EN
  logic [7:0] raw;

  // The delayed word borrows the previous raw word's trailing samples.
  assign o_nx = 8'({raw, word_nx} >> ph);

  // Delay line holding the previous unskewed word.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) raw <= IDLE_WORD;
    else        raw <= word_nx;
  end
`else
  assign o_nx = word_nx;
`endif

  // State, counter, shift register and the output word register.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state <= SER_IDLE;
      cnt   <= 6'd0;
      shreg <= '1;
      o     <= IDLE_WORD;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
      o     <= o_nx;
    end
  end

endmodule

// File: rtl/frame_tx.sv
// frame_tx: nibble collect and shadow buffering plus handshake in front of frame_tx_ser.
// Optional build macro: FRAME_TX_SKEW_EN (adds static ph port, sample delay 0..3).
module frame_tx
  import lvds_pkg::*;
#(
  parameter int GAP = 4
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic [3:0] s_d,
  input  logic       s_v,
  output logic       s_rdy,
  output logic [7:0] o,
  output logic       busy
`ifdef FRAME_TX_SKEW_EN
  ,
  input  logic [1:0] ph
`endif
);

  logic [DATA_BITS-1:0] col, sh;
  logic [3:0]           nib_cnt;
  logic                 col_full, sh_v, rdy_en;
  logic                 accept, take, col_to_sh;

  // Stall only when both buffer stages hold a complete frame.
  assign s_rdy     = rdy_en & ~(col_full & sh_v);
  assign accept    = s_v & s_rdy;
  assign col_to_sh = col_full & (~sh_v | take);

  // Handshake enable: low through reset, high from the first edge afterwards.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Collect stage: shift nibbles in so the first one ends up in the top nibble.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      nib_cnt  <= 4'd0;
      col_full <= 1'b0;
    end else begin
      if (accept) begin
        col     <= {col[DATA_BITS-5:0], s_d};
        nib_cnt <= nib_cnt + 4'd1;
      end
      if (accept && (nib_cnt == 4'(FRAME_NIBBLES - 1))) col_full <= 1'b1;
      else if (col_to_sh)                               col_full <= 1'b0;
    end
  end

  // Shadow stage: refilled from collect in the same edge the serializer empties it.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      sh_v <= 1'b0;
    end else begin
      if (col_to_sh) begin
        sh   <= col;
        sh_v <= 1'b1;
      end else if (take) begin
        sh_v <= 1'b0;
      end
    end
  end

  frame_tx_ser #(
    .GAP(GAP)
  ) u_ser (
    .c      (c),
    .rst_n  (rst_n),
    .load_d (sh),
    .load_v (sh_v),
    .take   (take),
    .o      (o),
    .busy   (busy)
`ifdef FRAME_TX_SKEW_EN
    ,
    .ph     (ph)
`endif
  );

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: directed bench for frame_tx with a word scoreboard fed from the stimulus side.
module tb_frame_tx;

  localparam int GAP = 4;
  localparam int FW  = 34 + GAP;
`ifdef FRAME_TX_SKEW_EN
  localparam int PH = 1;
  logic [1:0] ph = 2'd1;
`else
  localparam int PH = 0;
`endif

  logic       c = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_d = 4'd0;
  logic       s_v = 1'b0;
  logic       s_rdy, busy;
  logic [7:0] o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_count = 0;
  int acc_cyc = 0;
  logic [7:0] sb[$];
  int starts[$];
  logic [3:0] fr[16];

  frame_tx #(
    .GAP(GAP)
  ) dut (
    .c     (c),
    .rst_n (rst_n),
    .s_d   (s_d),
    .s_v   (s_v),
    .s_rdy (s_rdy),
    .o     (o),
    .busy  (busy)
`ifdef FRAME_TX_SKEW_EN
    ,
    .ph    (ph)
`endif
  );

  always #2 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected words of one frame plus its gap, built bit by bit from fr[].
  task automatic push_expected();
    logic [67:0] b;
    logic [7:0]  w, prev;
    logic [15:0] pr;
    b    = '1;
    b[0] = 1'b0;
    for (int n = 0; n < 16; n++)
      for (int k = 0; k < 4; k++)
        b[1+4*n+k] = fr[n][3-k];
    prev = 8'hFF;
    for (int k = 0; k < FW; k++) begin
      if (k < 34) w = {{4{b[2*k]}}, {4{b[2*k+1]}}};
      else        w = 8'hFF;
      pr = {prev, w} >> PH;
      sb.push_back(pr[7:0]);
      prev = w;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_nib(input logic [3:0] n);
    int g;
    s_v = 1'b1;
    s_d = n;
    g = 0;
    while (s_rdy !== 1'b1 && g < 100) begin
      @(negedge c);
      g++;
    end
    chk("rdy_wait", 32'(g < 100), 32'd1);
    @(posedge c);
    @(negedge c);
    acc_cyc = cyc;
  endtask

  task automatic send_frame(input int mode);
    int r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 15);
      if (mode == 0)      fr[i] = 4'hA;
      else if (mode == 1) fr[i] = 4'(i);
      else                fr[i] = 4'(r);
    end
    for (int i = 0; i < 16; i++) send_nib(fr[i]);
    push_expected();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 300) begin
      @(negedge c);
      g++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge c);
      if (!rst_n) begin
        pop_count = 0;
        sb.delete();
      end else if (busy === 1'b1) begin
        if (pop_count % FW == 0) starts.push_back(cyc);
        e = 8'hxx;
        if (sb.size() != 0) e = sb.pop_front();
        n_cmp++;
        assert (o === e) else begin
          n_err++;
          $error("FAIL frame_word[%0d] obs=%h exp=%h", pop_count % FW, o, e);
        end
        pop_count++;
      end else begin
        n_cmp++;
        assert (o === 8'hFF) else begin
          n_err++;
          $error("FAIL idle_word obs=%h exp=ff", o);
        end
      end
    end
  endtask

  initial begin
    logic [7:0]  wv[34];
    logic [67:0] bits;
    logic [15:0] pr;
    int e1, e3, g, nst;

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset behaviour and release.
    repeat (3) @(negedge c);
    chk("rst_o", 32'(o), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(s_rdy), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(s_rdy), 32'd0);
    @(negedge c);
    chk("rdy_after_edge", 32'(s_rdy), 32'd1);

    // Single all-A frame.
    send_frame(0);
    s_v = 1'b0;
    e1 = acc_cyc;
    repeat (2) @(negedge c);
    pr = {8'hFF, 8'h0F} >> PH;
    chk("a_word0", 32'(o), 32'(pr[7:0]));
    chk("a_busy", 32'(busy), 32'd1);
    repeat (33) @(negedge c);
    chk("a_word33", 32'(o), 32'hFF);
    chk("a_word33_busy", 32'(busy), 32'd1);
    wait_idle();
    chk("a_end_cycle", 32'(cyc - e1), 32'(2 + FW));

    // Counting nibbles: latency to word 0 and loopback decode.
    send_frame(1);
    s_v = 1'b0;
    repeat (2) @(negedge c);
    pr = {8'hFF, 8'h00} >> PH;
    chk("lat_word0", 32'(o), 32'(pr[7:0]));
    wv[0] = o;
    for (int k = 1; k < 34; k++) begin
      @(negedge c);
      wv[k] = o;
    end
    for (int k = 0; k < 34; k++) begin
      bits[2*k]   = wv[k][4];
      bits[2*k+1] = wv[k][0];
    end
    chk("lb_framing", 32'({bits[67:65], bits[0]}), 32'hE);
    for (int n = 0; n < 16; n++)
      chk("lb_nibble", 32'({bits[1+4*n], bits[2+4*n], bits[3+4*n], bits[4+4*n]}), 32'(n));
    wait_idle();

    // Back-to-back streaming of three frames.
    starts.delete();
    send_frame(2);
    e1 = acc_cyc;
    send_frame(2);
    send_frame(1);
    e3 = acc_cyc;
    s_v = 1'b0;
    chk("stream_no_stall", 32'(e3 - e1), 32'd32);
    chk("stall_active", 32'(s_rdy), 32'd0);
    g = 0;
    while (s_rdy !== 1'b1 && g < 100) begin
      @(negedge c);
      g++;
    end
    chk("rdy_return_cycle", 32'(cyc - e1), 32'd40);
    g = 0;
    while (starts.size() < 3 && g < 300) begin
      @(negedge c);
      g++;
    end
    chk("start_count", 32'(starts.size()), 32'd3);
    if (starts.size() >= 3) begin
      chk("start0", 32'(starts[0] - e1), 32'd2);
      chk("start_gap1", 32'(starts[1] - starts[0]), 32'(FW));
      chk("start_gap2", 32'(starts[2] - starts[1]), 32'(FW));
    end
    wait_idle();

    // Reset in frame cycle 10, then a clean frame.
    send_frame(2);
    s_v = 1'b0;
    repeat (12) @(negedge c);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_o", 32'(o), 32'hFF);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdy", 32'(s_rdy), 32'd0);
    repeat (2) @(negedge c);
    chk("mid_hold_o", 32'(o), 32'hFF);
    rst_n = 1'b1;
    @(negedge c);
    chk("mid_rdy_after", 32'(s_rdy), 32'd1);
    nst = starts.size();
    send_frame(2);
    s_v = 1'b0;
    e1 = acc_cyc;
    g = 0;
    while (starts.size() <= nst && g < 50) begin
      @(negedge c);
      g++;
    end
    chk("post_rst_start", 32'(starts.size() > nst), 32'd1);
    if (starts.size() > nst) chk("post_rst_lat", 32'(starts[$] - e1), 32'd2);
    wait_idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_tx.md
FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 SHALL have parameter GAP, default 4, meaning the number of idle (8'hFF) cycles inserted after each frame's stop bits, legal range 1..15.
REQ-002 SHALL have port c, input, 1 bit: the 400 MHz clock, with all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port s_d, input, 4 bits: payload nibble.
REQ-005 SHALL have port s_v, input, 1 bit: nibble valid.
REQ-006 SHALL have port s_rdy, output, 1 bit: nibble accepted on any rising edge of c with s_v && s_rdy.
REQ-007 SHALL have port o, output, 8 bits: raw sample word for a 3.2 GHz serializer; bit 7 is the oldest sample; sample spacing is 312.5 ps.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame (start, data, stop or gap) is on o.

Function
REQ-009 SHALL define a frame as 16 accepted nibbles forming D[63:0], with the first accepted nibble in D[63:60] and the MSB first within each nibble.
REQ-010 SHALL transmit the 68-bit sequence S = {1'b0 start, D[63:0], 3'b111 stop}, with S[0] sent first.
REQ-011 SHALL, in frame cycle k (k = 0..33), drive o = {4{S[2k]}, 4{S[2k+1]}}, i.e. 4 samples per bit and 2 bits per cycle (800 Mb/s).
REQ-012 SHALL drive o = 8'hFF in every cycle that is not a frame cycle, including GAP cycles and the idle state.
REQ-013 SHALL buffer input in two stages: a collect register (64-bit, with a 4-bit nibble counter) and a shadow register loaded into the serializer.
REQ-014 SHALL, when the 16th nibble is accepted in cycle N and the serializer is in IDLE, start frame cycle 0 on o at cycle N+2.
REQ-015 SHALL, if the serializer is busy when the collect register fills, hold the frame in the shadow register and start it in the first cycle after GAP ends.
REQ-016 SHALL hold s_rdy low only while the collect register is full and the shadow register is occupied.
REQ-017 SHALL, on a simultaneous shadow-to-serializer transfer and collect-to-shadow transfer, perform both with no nibble lost or duplicated.
REQ-018 SHALL implement serializer FSM states IDLE -> DATA (cycles 0..33, 6-bit counter) -> GAP (GAP cycles) -> IDLE, or GAP -> DATA when the shadow register is valid.
REQ-019 SHALL give back-to-back frames a start-to-start period of exactly 34+GAP cycles.
REQ-020 SHALL NOT let s_v and s_d affect o while a frame is in flight; a frame is never aborted except by reset.
REQ-021 SHALL register o directly from a flop, with no combinational path from inputs to o.

Reset
REQ-022 SHALL, while rst_n = 0, immediately force o = 8'hFF, busy = 0 and s_rdy = 0.
REQ-023 SHALL, while rst_n = 0, clear the nibble counter, the shadow-valid flag and the FSM (to IDLE).
REQ-024 SHALL drive s_rdy = 1 on the first edge after rst_n deasserts.
REQ-025 SHALL, on reset mid-frame, drop the partial frame and drive o = 8'hFF with no truncated start or data.

Configuration
REQ-026 SHALL, with FRAME_TX_SKEW_EN defined, add port ph (input, 2 bits, static) and delay the sample stream by ph samples (0..3) using the previous word's low samples; the delay line resets to ones.
REQ-027 SHALL, without FRAME_TX_SKEW_EN, have no ph port and apply zero sample delay.

Structure
REQ-028 SHALL place the shared constants in package lvds_pkg: FRAME_NIBBLES = 16, STOP_BITS = 3, SAMPLES_PER_BIT = 4, IDLE_WORD = 8'hFF, FRAME_CYCLES = 34.
REQ-029 SHALL implement the FSM, shift register and sample expansion in sub-module frame_tx_ser, with frame_tx holding the collect and shadow buffers and the handshake.

Verification
REQ-030 SHALL cover reset: rst_n low -> o = 8'hFF, busy = 0, s_rdy = 0; rst_n released -> s_rdy = 1 on the next edge.
REQ-031 SHALL cover a single frame: 16 nibbles of 4'hA accepted on consecutive cycles -> o = 8'h0F for frame cycles 0..32, o = 8'hFF at cycle 33, then 8'hFF continuously.
REQ-032 SHALL cover a latency and content check: nibbles 0..F -> cycle 0 word 8'h00 appears 2 cycles after the 16th accept, and a loopback into the receiver yields nibbles 0..F in order.
REQ-033 SHALL cover back-to-back streaming: continuous s_v for 48 nibbles -> 3 frames with starts spaced 38 cycles apart (GAP = 4), and s_rdy low only while collect is full with shadow occupied.
REQ-034 SHALL cover reset mid-frame: rst_n pulsed at frame cycle 10 -> o = 8'hFF immediately, and the next 16 nibbles form a clean new frame.
REQ-035 SHALL cover the skew option: FRAME_TX_SKEW_EN defined, ph = 1, nibbles all 4'hA -> cycle 0 word 8'h87 and subsequent frame words 8'h87.
